// File: rtl/jg_pkg.sv
// Shared helpers for the Johnson/Gray counter: Gray conversion, Johnson encoding
// of a binary index, and the legality rule for Johnson vectors.
package jg_pkg;

    localparam int JG_MAX_W           = 64;
    localparam int JG_MAX_TRANSITIONS = 1;

    function automatic int bin2gray(input int value, input int width);
        int r;
        r = value ^ (value >>> 1);
        for (int i = 0; i < 32; i++) begin
            if (i >= width) r[i] = 1'b0;
        end
        return r;
    endfunction

    // Ones fill from the LSB up to idx, then drain from the LSB for idx > n.
    function automatic logic [JG_MAX_W-1:0] johnson_from_idx(input int idx, input int n);
        logic [JG_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < JG_MAX_W; i++) begin
            if (i < n) begin
                if (idx <= n) r[i] = (i < idx);
                else          r[i] = (i >= idx - n);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-vector decoder: binary index, Gray code and legality flag.
module johnson_decode
    import jg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]             j,
    output logic [$clog2(2*N)-1:0]   idx,
    output logic [$clog2(2*N)-1:0]   g,
    output logic                     valid
);

    localparam int GW = $clog2(2*N);

    always_comb begin
        int pop;
        int trans;
        int idx_i;
        pop   = 0;
        trans = 0;
        for (int i = 0; i < N; i++) begin
            pop += int'(j[i]);
        end
        for (int i = 0; i < N-1; i++) begin
            if (j[i] != j[i+1]) trans++;
        end
        // Upper half of the ring has the MSB set and counts down in ones.
        idx_i = j[N-1] ? (2*N - pop) : pop;
        idx   = GW'(idx_i);
        g     = GW'(bin2gray(idx_i, GW));
        valid = (trans <= JG_MAX_TRANSITIONS);
    end

endmodule

// File: rtl/johnson_gray_counter.sv
// Bidirectional, loadable N-bit Johnson counter with registered Gray/binary index
// and wrap pulse. Define JOHNSON_GRAY_SELFCHECK_EN to build illegal-state recovery.
module johnson_gray_counter
    import jg_pkg::*;
#(
    parameter  int N  = 4,
    localparam int GW = $clog2(2*N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          dir,
    input  logic          load,
    input  logic [GW-1:0] load_idx,
    output logic [N-1:0]  j,
    output logic [GW-1:0] g,
    output logic [GW-1:0] idx,
    output logic          wrap,
    output logic          err
);

    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("johnson_gray_counter: N must be a power of two and >= 2");
    end

    logic [N-1:0]  j_nxt;
    logic [N-1:0]  load_j;
    logic [GW-1:0] g_nxt;
    logic [GW-1:0] idx_nxt;
    logic          wrap_nxt;
    logic          nxt_valid_unused;

    assign load_j = N'(johnson_from_idx(int'(load_idx), N));

`ifdef JOHNSON_GRAY_SELFCHECK_EN
    logic j_legal;
    logic err_nxt;

    always_comb begin
        int trans;
        trans = 0;
        for (int i = 0; i < N-1; i++) begin
            if (j[i] != j[i+1]) trans++;
        end
        j_legal = (trans <= JG_MAX_TRANSITIONS);
    end
`endif

    always_comb begin
        j_nxt    = j;
        wrap_nxt = 1'b0;
`ifdef JOHNSON_GRAY_SELFCHECK_EN
        err_nxt  = err;
`endif
        if (load) begin
            j_nxt = load_j;
`ifdef JOHNSON_GRAY_SELFCHECK_EN
        end else if (!j_legal) begin
            j_nxt   = '0;
            err_nxt = 1'b1;
`endif
        end else if (en) begin
            if (dir) begin
                j_nxt    = {j[N-2:0], ~j[N-1]};
                wrap_nxt = (idx == GW'(2*N - 1));
            end else begin
                j_nxt    = {~j[0], j[N-1:1]};
                wrap_nxt = (idx == '0);
            end
        end
    end

    // Decode the next state so index and Gray register in the same edge as j.
    johnson_decode #(.N(N)) u_nxt_dec (
        .j     (j_nxt),
        .idx   (idx_nxt),
        .g     (g_nxt),
        .valid (nxt_valid_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            j    <= '0;
            g    <= '0;
            idx  <= '0;
            wrap <= 1'b0;
        end else begin
            j    <= j_nxt;
            g    <= g_nxt;
            idx  <= idx_nxt;
            wrap <= wrap_nxt;
        end
    end

`ifdef JOHNSON_GRAY_SELFCHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) err <= 1'b0;
        else        err <= err_nxt;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_gray_counter.sv
// Scoreboard bench for johnson_gray_counter: directed vectors for N=4 and N=8.
module tb_johnson_gray_counter;

    typedef struct {
        logic [7:0] j;
        logic [3:0] g;
        logic [3:0] idx;
        logic       wrap;
        logic       err;
        logic       step;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en4 = 1'b0, dir4 = 1'b1, load4 = 1'b0;
    logic [2:0] lidx4 = '0;
    logic       en8 = 1'b0, dir8 = 1'b1, load8 = 1'b0;
    logic [3:0] lidx8 = '0;

    logic [3:0] j4;
    logic [2:0] g4, idx4;
    logic       wrap4, err4;
    logic [7:0] j8;
    logic [3:0] g8, idx8;
    logic       wrap8, err8;

    exp_t q4[$];
    exp_t q8[$];
    int   checks = 0;
    int   failures = 0;
    logic exp_err4 = 1'b0;

    always #5 clk = ~clk;

    johnson_gray_counter #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .dir(dir4), .load(load4), .load_idx(lidx4),
        .j(j4), .g(g4), .idx(idx4), .wrap(wrap4), .err(err4)
    );

    johnson_gray_counter #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .dir(dir8), .load(load8), .load_idx(lidx8),
        .j(j8), .g(g8), .idx(idx8), .wrap(wrap8), .err(err8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each edge that has a pending expectation is compared 2 time units later.
    logic [3:0] prev_g8 = '0;
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk({e.name, ".j"},    32'(j4),    32'(e.j[3:0]));
            chk({e.name, ".g"},    32'(g4),    32'(e.g[2:0]));
            chk({e.name, ".idx"},  32'(idx4),  32'(e.idx[2:0]));
            chk({e.name, ".wrap"}, 32'(wrap4), 32'(e.wrap));
            chk({e.name, ".err"},  32'(err4),  32'(e.err));
        end
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk({e.name, ".j"},    32'(j8),    32'(e.j));
            chk({e.name, ".g"},    32'(g8),    32'(e.g));
            chk({e.name, ".idx"},  32'(idx8),  32'(e.idx));
            chk({e.name, ".wrap"}, 32'(wrap8), 32'(e.wrap));
            chk({e.name, ".err"},  32'(err8),  32'(e.err));
            if (e.step) chk({e.name, ".g_onebit"}, 32'($countones(g8 ^ prev_g8)), 32'd1);
            prev_g8 = g8;
        end
    end

    task automatic drive4(input logic r, input logic e, input logic d, input logic l,
                          input logic [2:0] li, input logic [3:0] xj, input logic [2:0] xg,
                          input logic [2:0] xi, input logic xw, input string nm);
        exp_t x;
        @(negedge clk);
        rst_n = r; en4 = e; dir4 = d; load4 = l; lidx4 = li;
        x.j = {4'b0, xj}; x.g = {1'b0, xg}; x.idx = {1'b0, xi};
        x.wrap = xw; x.err = exp_err4; x.step = 1'b0; x.name = nm;
        q4.push_back(x);
    endtask

    task automatic drive8(input logic e, input logic d, input logic [7:0] xj,
                          input logic [3:0] xg, input logic [3:0] xi, input logic xw,
                          input logic st, input string nm);
        exp_t x;
        @(negedge clk);
        en8 = e; dir8 = d; load8 = 1'b0; lidx8 = '0;
        x.j = xj; x.g = xg; x.idx = xi; x.wrap = xw; x.err = 1'b0; x.step = st; x.name = nm;
        q8.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] t1_j[8];
        logic [2:0] t1_g[8];
        logic [3:0] t5_j[6];
        logic [2:0] t5_g[6];
        logic [7:0] t4_j[16];
        logic [3:0] t4_g[16];
        t1_j = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        t1_g = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
        t5_j = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC};
        t5_g = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5};
        t4_j = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        t4_g = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

        // Reset with en asserted
        drive4(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b0, "reset");
        drive4(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 4'h0, 3'd0, 3'd0, 1'b0, "reset2");

        // Full forward lap, wrap on return to 0
        for (int i = 0; i < 8; i++)
            drive4(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, t1_j[i], t1_g[i], 3'((i + 1) % 8),
                   (i == 7), $sformatf("fwd%0d", i));

        // Reverse from 0
        drive4(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'h8, 3'd4, 3'd7, 1'b1, "rev0");
        drive4(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'hC, 3'd5, 3'd6, 1'b0, "rev1");

        // Load beats en, then hold
        drive4(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 4'hE, 3'd7, 3'd5, 1'b0, "load5");
        drive4(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'hE, 3'd7, 3'd5, 1'b0, "hold");

        // Load boundaries: load never wraps; forward step from 7 does
        drive4(1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 4'h8, 3'd4, 3'd7, 1'b0, "load7");
        drive4(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 4'h0, 3'd0, 3'd0, 1'b0, "load0");
        drive4(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 4'hF, 3'd6, 3'd4, 1'b0, "load4");
        drive4(1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 4'h8, 3'd4, 3'd7, 1'b0, "load7b");
        drive4(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b1, "wrapfwd");
        drive4(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b0, "wraphold");

        // Mid-run reset at idx 6 with en and load high
        for (int i = 0; i < 6; i++)
            drive4(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, t5_j[i], t5_g[i], 3'(i + 1), 1'b0,
                   $sformatf("run%0d", i));
        drive4(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 4'h0, 3'd0, 3'd0, 1'b0, "midreset");
        drive4(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'h1, 3'd1, 3'd1, 1'b0, "resume0");
        drive4(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'h3, 3'd3, 3'd2, 1'b0, "resume1");
        drive4(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'h3, 3'd3, 3'd2, 1'b0, "resume_hold");

`ifdef JOHNSON_GRAY_SELFCHECK_EN
        // Illegal state injection and sticky err
        @(negedge clk);
        en4 = 1'b0; load4 = 1'b0;
        force dut4.j = 4'b0101;
        @(posedge clk);
        #1 release dut4.j;
        exp_err4 = 1'b1;
        drive4(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b0, "recover");
        drive4(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'h1, 3'd1, 3'd1, 1'b0, "sticky0");
        drive4(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'h3, 3'd3, 3'd2, 1'b0, "sticky1");
        exp_err4 = 1'b0;
        drive4(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b0, "errclear");
        drive4(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'h0, 3'd0, 3'd0, 1'b0, "errclear_hold");
`endif

        // N=8 forward lap; dut4 idles
        @(negedge clk);
        en4 = 1'b0; load4 = 1'b0;
        for (int i = 0; i < 16; i++)
            drive8(1'b1, 1'b1, t4_j[i], t4_g[i], 4'((i + 1) % 16), (i == 15), 1'b1,
                   $sformatf("n8fwd%0d", i));
        drive8(1'b0, 1'b1, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, "n8hold");
        drive8(1'b1, 1'b0, 8'h80, 4'h8, 4'hF, 1'b1, 1'b1, "n8rev");

        @(negedge clk);
        en8 = 1'b0;
        repeat (3) @(negedge clk);
        if (q4.size() != 0 || q8.size() != 0) begin
            failures++;
            $display("FAIL drain: q4=%0d q8=%0d entries left unchecked", q4.size(), q8.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
